// File: rtl/seq_divider_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_divider_pkg
// Description : Shared types and helpers for the sequential restoring divider.
//               Holds the FSM state encoding, the default datapath width and
//               the iteration-counter width helper.
// Revision    : 1.0  initial release
// ============================================================================
package seq_divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    // Bits needed to count WIDTH-1 down to 0; never narrower than one bit.
    function automatic int cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_divider_step.sv
`default_nettype none
// ============================================================================
// Module      : div_step
// Description : One combinational compare-subtract iteration of a restoring
//               divider. Shifts the next dividend bit into the partial
//               remainder and subtracts the divisor when it fits.
// Ports       : rem      partial remainder (always < divisor on entry)
//               q_msb    dividend bit shifted into the remainder
//               divisor  divisor (non-zero)
//               rem_next updated partial remainder
//               q_bit    quotient bit produced by this iteration
// Revision    : 1.0  initial release
// ============================================================================
module div_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             q_msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    logic [WIDTH:0]   w_shift;
    logic [WIDTH-1:0] w_diff;

    assign w_shift = {rem, q_msb};
    assign q_bit   = (w_shift >= {1'b0, divisor});

    // rem < divisor on entry, so w_shift < 2*divisor and the true difference
    // always fits in WIDTH bits; modular WIDTH-bit subtraction is exact here.
    assign w_diff   = w_shift[WIDTH-1:0] - divisor;
    assign rem_next = q_bit ? w_diff : w_shift[WIDTH-1:0];

endmodule
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module      : seq_divider
// Description : Multi-cycle unsigned restoring divider, one quotient bit per
//               clock, valid/ready handshake on operands and on results.
//               One operation in flight at a time.
// Ports       : clk, rst_n                 clock, async active-low reset
//               in_valid/in_ready          operand handshake (IDLE only)
//               dividend, divisor          operands, sampled on accept
//               out_valid/out_ready        result handshake (DONE only)
//               quotient, remainder        registered results
//               div_by_zero                divisor was zero for this result
// Revision    : 1.0  initial release
// ============================================================================
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int                CNT_W      = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0]  C_CNT_INIT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]  C_CNT_ONE  = CNT_W'(1);
    localparam logic [WIDTH-1:0]  C_ZERO     = '0;

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_divisor;

    logic             w_accept;
    logic             w_last;
    logic [WIDTH-1:0] w_rem_next;
    logic             w_q_bit;
    logic [WIDTH-1:0] w_q_next;

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign w_accept  = in_valid && in_ready;
    assign w_last    = (r_state == BUSY) && (r_cnt == '0);

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem      (r_rem),
        .q_msb    (r_q[WIDTH-1]),
        .divisor  (r_divisor),
        .rem_next (w_rem_next),
        .q_bit    (w_q_bit)
    );

    // r_q doubles as the dividend shifter: its MSB feeds the remainder while
    // quotient bits fill in from the LSB.
    assign w_q_next = {r_q[WIDTH-2:0], w_q_bit};

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_state_next = (divisor == C_ZERO) ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (r_cnt == '0) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // ----------------------------------------------------------- datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_q         <= '0;
            r_rem       <= '0;
            r_divisor   <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (w_accept) begin
            r_divisor <= divisor;
            r_q       <= dividend;
            r_rem     <= '0;
            r_cnt     <= C_CNT_INIT;
            if (divisor == C_ZERO) begin
                // Result is produced directly, the BUSY loop is skipped.
                quotient    <= '1;
                remainder   <= dividend;
                div_by_zero <= 1'b1;
            end else begin
                div_by_zero <= 1'b0;
            end
        end else if (r_state == BUSY) begin
            r_rem <= w_rem_next;
            r_q   <= w_q_next;
            if (w_last) begin
                quotient  <= w_q_next;
                remainder <= w_rem_next;
            end else begin
                r_cnt <= r_cnt - C_CNT_ONE;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_seq_divider
// Description : Self-checking bench for seq_divider (WIDTH = 8). Results are
//               compared against plain / and % arithmetic.
// Revision    : 1.0  initial release
// ============================================================================
module tb_seq_divider;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    int n_assert = 0;
    int n_fail   = 0;

    seq_divider #(
        .WIDTH (WIDTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "simulation timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Starts at a negedge, ends at the negedge after the result hand-off.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          input int bp, input bit hold);
        int         n;
        logic [7:0] eq;
        logic [7:0] er;
        logic       edbz;
        if (b == 8'd0) begin
            eq = 8'hFF; er = a; edbz = 1'b1;
        end else begin
            eq = a / b; er = a % b; edbz = 1'b0;
        end

        n = 0;
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_before", in_ready, 1);
        dividend  = a;
        divisor   = b;
        in_valid  = 1'b1;
        out_ready = (bp == 0);
        @(posedge clk);
        #1;
        if (!hold) in_valid = 1'b0;
        dividend = 8'($urandom);
        divisor  = 8'($urandom);

        @(negedge clk);
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            dividend = 8'($urandom);
            divisor  = 8'($urandom);
        end
        check("latency", n, (b == 8'd0) ? 0 : WIDTH);
        check("out_valid", out_valid, 1);
        check("in_ready_done", in_ready, 0);
        check("quotient", quotient, eq);
        check("remainder", remainder, er);
        check("div_by_zero", div_by_zero, edbz);

        if (bp > 0) begin
            for (int i = 0; i < bp; i++) begin
                @(negedge clk);
                check("hold_valid", out_valid, 1);
                check("hold_quotient", quotient, eq);
                check("hold_remainder", remainder, er);
                check("hold_in_ready", in_ready, 0);
            end
            out_ready = 1'b1;
        end

        @(posedge clk);
        @(negedge clk);
        check("out_valid_after", out_valid, 0);
        check("in_ready_after", in_ready, 1);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        dividend  = '0;
        divisor   = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_quotient", quotient, 0);
        check("rst_remainder", remainder, 0);
        check("rst_div_by_zero", div_by_zero, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases and boundaries
        run_op(8'd200, 8'd7, 0, 1'b0);
        run_op(8'd255, 8'd1, 0, 1'b0);
        run_op(8'd5,   8'd9, 0, 1'b0);
        run_op(8'd0,   8'd3, 0, 1'b0);
        run_op(8'd77,  8'd0, 0, 1'b0);
        run_op(8'd100, 8'd10, 20, 1'b0);

        // Reset in the middle of a BUSY operation
        dividend = 8'd200;
        divisor  = 8'd7;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("busy_in_ready", in_ready, 0);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_quotient", quotient, 0);
        check("midrst_remainder", remainder, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(8'd9, 8'd2, 0, 1'b0);

        // Back-to-back random operations with in_valid held high
        for (int k = 0; k < 10; k++) begin
            logic [7:0] ra;
            logic [7:0] rb;
            ra = 8'($urandom);
            rb = (k == 3) ? 8'd0 : 8'($urandom_range(1, 255));
            run_op(ra, rb, 0, 1'b1);
        end
        in_valid = 1'b0;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
